// File: rtl/prbs17_pkg.sv
// Shared definitions for the 17-bit Fibonacci PRBS (x^17 + x^14 + 1).
// Used by both the generator and the checker.
package prbs17_pkg;

  localparam int PRBS_W = 17;
  localparam int TAP_HI = 16;
  localparam int TAP_LO = 13;

  typedef enum logic [1:0] {
    FILL,
    HUNT,
    LOCKED
  } chk_state_t;

  function automatic logic prbs17_next_bit(
    input logic [PRBS_W-1:0] s
  );
    return s[TAP_HI] ^ s[TAP_LO];
  endfunction

endpackage

// File: rtl/prbs17_checker.sv
// Self-synchronising PRBS17 receive checker.
// Fills, hunts for lock, then free-runs and counts bit errors.
module prbs17_checker
  import prbs17_pkg::*;
#(
  parameter int LOCK_COUNT  = 32,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int FC_W = 5;
  localparam int MC_W = 8;
  localparam int WC_W = $clog2(WINDOW);
  localparam int WE_W = $clog2(WINDOW + 1);

  localparam logic [FC_W-1:0] FILL_LAST =
    FC_W'(PRBS_W - 1);
  localparam logic [MC_W-1:0] LOCK_LAST =
    MC_W'(LOCK_COUNT - 1);
  localparam logic [WC_W-1:0] WIN_LAST =
    WC_W'(WINDOW - 1);
  localparam logic [WE_W-1:0] LOSS_N =
    WE_W'(LOSS_THRESH);

  chk_state_t        state_q, state_n;
  logic [PRBS_W-1:0] s_q, s_n;
  logic [FC_W-1:0]   fill_q, fill_n;
  logic [MC_W-1:0]   match_q, match_n;
  logic [WC_W-1:0]   wcnt_q, wcnt_n;
  logic [WE_W-1:0]   werr_q, werr_n;
  logic [WE_W-1:0]   werr_inc;

  logic                 e_bit;
  logic                 mism;
  logic                 hit;
  logic                 locked_n;
  logic                 err_pulse_n;
  logic [ERR_CNT_W-1:0] err_count_n;

  assign e_bit = prbs17_next_bit(s_q);
  assign mism  = bit_in ^ e_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      s_q       <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      wcnt_q    <= '0;
      werr_q    <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_n;
      s_q       <= s_n;
      fill_q    <= fill_n;
      match_q   <= match_n;
      wcnt_q    <= wcnt_n;
      werr_q    <= werr_n;
      locked    <= locked_n;
      err_pulse <= err_pulse_n;
      err_count <= err_count_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    s_n      = s_q;
    fill_n   = fill_q;
    match_n  = match_q;
    wcnt_n   = wcnt_q;
    werr_n   = werr_q;
    werr_inc = werr_q + WE_W'(mism);
    if (bit_valid) begin
      unique case (state_q)
        FILL: begin
          s_n    = {s_q[PRBS_W-2:0], bit_in};
          fill_n = fill_q + 1'b1;
          if (fill_q == FILL_LAST) begin
            state_n = HUNT;
            match_n = '0;
          end
        end
        HUNT: begin
          s_n = {s_q[PRBS_W-2:0], bit_in};
          if (!mism && s_q != '0) begin
            match_n = match_q + 1'b1;
            if (match_q == LOCK_LAST) begin
              state_n = LOCKED;
              wcnt_n  = '0;
              werr_n  = '0;
            end
          end else begin
            match_n = '0;
          end
        end
        LOCKED: begin
          // Free-run on the local prediction so one
          // channel error never propagates.
          s_n = {s_q[PRBS_W-2:0], e_bit};
          if (wcnt_q == WIN_LAST) begin
            wcnt_n = '0;
            werr_n = '0;
          end else begin
            wcnt_n = wcnt_q + 1'b1;
            werr_n = werr_inc;
          end
          if (werr_inc == LOSS_N) begin
            state_n = FILL;
            fill_n  = '0;
          end
        end
        default: state_n = FILL;
      endcase
    end
  end

  always_comb begin
    hit = bit_valid && (state_q == LOCKED) && mism;
    err_pulse_n = hit;
    err_count_n = err_count;
    if (clear_cnt)
      err_count_n = '0;
    else if (hit && err_count != '1)
      err_count_n = err_count + 1'b1;
    locked_n = (state_n == LOCKED);
  end

endmodule

// File: tb/tb_prbs17_checker.sv
// Randomised bench for prbs17_checker against a
// bit-history reference model.
module tb_prbs17_checker;

  localparam int LOCK_COUNT  = 32;
  localparam int WINDOW      = 64;
  localparam int LOSS_THRESH = 8;
  localparam int CNT_MAX     = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  int n_chk  = 0;
  int n_fail = 0;

  prbs17_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .WINDOW     (WINDOW),
    .LOSS_THRESH(LOSS_THRESH),
    .ERR_CNT_W  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_valid(bit_valid),
    .bit_in   (bit_in),
    .clear_cnt(clear_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Generator: the spec's transmitted stream
  logic [16:0] q;

  function automatic bit gen();
    q = {q[15:0], q[16] ^ q[13]};
    return q[0];
  endfunction

  // Model: last 17 reference bits, oldest first
  bit hist[$];
  int m_mode;
  int m_fill;
  int m_match;
  int m_wcnt;
  int m_werr;
  int m_cnt;
  bit m_pulse;
  bit m_locked;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 17; i++) hist.push_back(1'b0);
    m_mode   = 0;
    m_fill   = 0;
    m_match  = 0;
    m_wcnt   = 0;
    m_werr   = 0;
    m_cnt    = 0;
    m_pulse  = 1'b0;
    m_locked = 1'b0;
  endtask

  task automatic model_step(
    input bit v,
    input bit b,
    input bit clr
  );
    bit pred;
    bit hit;
    bit zero;
    hit = 1'b0;
    if (v) begin
      pred = hist[0] ^ hist[3];
      zero = 1'b1;
      foreach (hist[i]) if (hist[i]) zero = 1'b0;
      if (m_mode == 0) begin
        hist.push_back(b);
        m_fill++;
        if (m_fill == 17) begin
          m_mode  = 1;
          m_match = 0;
        end
      end else if (m_mode == 1) begin
        hist.push_back(b);
        if (b == pred && !zero) m_match++;
        else m_match = 0;
        if (m_match == LOCK_COUNT) begin
          m_mode = 2;
          m_wcnt = 0;
          m_werr = 0;
        end
      end else begin
        hist.push_back(pred);
        if (b != pred) begin
          hit = 1'b1;
          m_werr++;
        end
        if (m_werr == LOSS_THRESH) begin
          m_mode = 0;
          m_fill = 0;
        end
        m_wcnt++;
        if (m_wcnt == WINDOW) begin
          m_wcnt = 0;
          m_werr = 0;
        end
      end
      void'(hist.pop_front());
    end
    m_pulse = hit;
    if (clr) m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    m_locked = (m_mode == 2);
  endtask

  // One clock: drive, edge, update model, compare.
  task automatic step(
    input bit rn,
    input bit v,
    input bit b,
    input bit clr
  );
    rst_n     = rn;
    bit_valid = v;
    bit_in    = b;
    clear_cnt = clr;
    @(posedge clk);
    #1;
    if (!rn) model_reset();
    else model_step(v, b, clr);
    chk("locked", 32'(locked), 32'(m_locked));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_count", 32'(err_count), 32'(m_cnt));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_count", 32'(err_count), 32'd0);
  endtask

  initial begin
    int lock_at;
    int pulses;
    int nv;
    bit b;
    bit v;

    model_reset();
    do_reset();

    // Clean stream: lock after 49 bits, no errors
    q = 17'h0002B;
    lock_at = -1;
    for (int i = 1; i <= 10000; i++) begin
      step(1'b1, 1'b1, gen(), 1'b0);
      if (locked && lock_at < 0) lock_at = i;
    end
    chk("lock_at", 32'(lock_at), 32'd49);
    chk("clean_cnt", 32'(err_count), 32'd0);

    // Single inverted bit
    step(1'b1, 1'b1, ~gen(), 1'b0);
    chk("one_pulse", 32'(err_pulse), 32'd1);
    chk("one_cnt", 32'(err_count), 32'd1);
    chk("one_lock", 32'(locked), 32'd1);
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b1, gen(), 1'b0);
      if (err_pulse) pulses++;
    end
    chk("no_mult", 32'(pulses), 32'd0);

    // Eight errors in one window force loss
    step(1'b1, 1'b1, gen(), 1'b1);
    chk("clr_cnt", 32'(err_count), 32'd0);
    for (int i = 0; i < WINDOW && m_wcnt != 0; i++)
      step(1'b1, 1'b1, gen(), 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) chk("pre_loss", 32'(locked), 32'd1);
      step(1'b1, 1'b1, ~gen(), 1'b0);
      if (k < 7)
        for (int j = 0; j < 3; j++)
          step(1'b1, 1'b1, gen(), 1'b0);
    end
    chk("loss", 32'(locked), 32'd0);
    chk("loss_cnt", 32'(err_count), 32'd8);
    lock_at = -1;
    for (int i = 1; i <= 200 && lock_at < 0; i++) begin
      step(1'b1, 1'b1, gen(), 1'b0);
      if (locked) lock_at = i;
    end
    chk("relock_at", 32'(lock_at), 32'd49);
    chk("kept_cnt", 32'(err_count), 32'd8);

    // Random gaps, clean data
    do_reset();
    q = 17'(($urandom % 17'h1FFFE) + 1);
    nv = 0;
    lock_at = -1;
    for (int i = 0; i < 1000 && lock_at < 0; i++) begin
      v = 1'($urandom_range(0, 1));
      b = v ? gen() : 1'($urandom_range(0, 1));
      step(1'b1, v, b, 1'b0);
      if (v) nv++;
      if (locked && lock_at < 0) lock_at = nv;
    end
    chk("gap_lock_at", 32'(lock_at), 32'd49);
    chk("gap_cnt", 32'(err_count), 32'd0);

    // Random gaps, errors and clears
    for (int i = 0; i < 4000; i++) begin
      v = 1'($urandom_range(0, 1));
      b = v ? gen() : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) b = ~b;
      step(1'b1, v, b,
           $urandom_range(0, 300) == 0);
    end

    // Clear coincident with an error
    do_reset();
    q = 17'h0002B;
    for (int i = 0; i < 49; i++)
      step(1'b1, 1'b1, gen(), 1'b0);
    chk("c_lock", 32'(locked), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, ~gen(), 1'b0);
      for (int j = 0; j < 19; j++)
        step(1'b1, 1'b1, gen(), 1'b0);
    end
    chk("c_five", 32'(err_count), 32'd5);
    step(1'b1, 1'b1, ~gen(), 1'b1);
    chk("c_pulse", 32'(err_pulse), 32'd1);
    chk("c_zero", 32'(err_count), 32'd0);
    step(1'b1, 1'b1, ~gen(), 1'b0);
    chk("c_one", 32'(err_count), 32'd1);
    step(1'b0, 1'b1, gen(), 1'b0);
    chk("r_locked", 32'(locked), 32'd0);
    chk("r_count", 32'(err_count), 32'd0);

    // All-zero stream never locks
    do_reset();
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (locked) pulses++;
    end
    chk("zero_lock", 32'(pulses), 32'd0);
    chk("zero_cnt", 32'(err_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs17_checker.md
# prbs17_checker

Serial receiver-side checker for the 17-bit Fibonacci PRBS stream (polynomial x^17 + x^14 + 1) produced by the project's random generator. It self-synchronises to the incoming bit stream, declares lock, then free-runs a local LFSR and counts bit errors against it. It sits at the far end of any link or test path carrying the generator's serial output, and provides a pass/fail monitor for board bring-up and simulation.

## Interface
- LOCK_COUNT, 32: consecutive correct predicted bits required to declare lock (1..255).
- WINDOW, 64: valid-bit window length for loss-of-lock evaluation (2..1024).
- LOSS_THRESH, 8: errors within one window that force loss of lock (1..WINDOW).
- ERR_CNT_W, 16: width of error counter.
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- bit_valid  in  1  qualifies bit_in; nothing advances when low.
- bit_in  in  1  received PRBS bit.
- clear_cnt  in  1  synchronous clear of err_count.
- locked  out  1  registered; high while in LOCKED.
- err_pulse  out  1  registered; one-cycle pulse per mismatched bit in LOCKED.
- err_count  out  ERR_CNT_W  registered, saturating count of errors seen in LOCKED.

## Operation
- Stream definition: generator state Q advances Q <= {Q[15:0], Q[16]^Q[13]}; the transmitted bit per step is the new LSB. Checker shift register S (17 b) mirrors Q; expected bit e = S[16]^S[13].
- States: FILL, HUNT, LOCKED. Reset -> FILL, S=0, all counters 0, all outputs 0.
- FILL: each valid bit shifts S <= {S[15:0], bit_in}; after 17 valid bits -> HUNT, match counter 0.
- HUNT: each valid bit compares bit_in to e, then S <= {S[15:0], bit_in} (received bit, self-sync). Match and S != 0 -> match counter +1; mismatch or S == 0 -> match counter 0. Match counter reaching LOCK_COUNT -> LOCKED, window counter 0, window error count 0. No err_pulse/err_count activity in HUNT.
- LOCKED: each valid bit shifts S <= {S[15:0], e} (local bit, free-run; one channel error gives exactly one error, no multiplication). Mismatch -> err_pulse, err_count +1 (saturate at all-ones), window error count +1.
- Window: counter over valid bits 0..WINDOW-1; on the bit completing the window, window error count restarts at 0 (that bit's error, if any, is still evaluated against the old window first).
- Loss: window error count reaching LOSS_THRESH -> FILL next cycle, S unchanged but fill counter 0, locked falls.
- clear_cnt: err_count <= 0; clear has priority over a simultaneous error (count ends at 0, err_pulse still asserts).
- err_count retains its value across loss of lock; only reset or clear_cnt zeroes it.

## Timing
- Compare/shift on the clock edge where bit_valid is sampled high; err_pulse and err_count update on that same edge (visible one cycle after the bit is presented).
- locked rises on the edge that accepts the LOCK_COUNT-th consecutive match: with clean data from reset, locked high after 17 + LOCK_COUNT valid bits (49 by default).
- locked falls on the edge accepting the LOSS_THRESH-th error in a window.
- bit_valid low: S, counters, state frozen; err_pulse 0.
- rst_n low mid-operation: next edge returns to reset state regardless of bit_valid/clear_cnt.

## Structure
- Package prbs17_pkg: PRBS_W=17, TAP_HI=16, TAP_LO=13, state enum {FILL, HUNT, LOCKED}, function prbs17_next_bit(S) returning S[TAP_HI]^S[TAP_LO]. Generator and checker share these.
- Single module; no sub-module. Window/loss logic is small enough to stay inline.

## Test plan
- Clean stream from seed 17'h0002B, bit_valid always high -> locked rises after exactly 49 bits; err_count stays 0 over 10000 bits.
- After lock, invert one bit -> one err_pulse, err_count = 1, locked stays high; next 200 bits clean, no further pulses.
- After lock, invert 8 bits within 64 -> locked falls on 8th error, relocks 49 clean bits later; err_count = 8 retained.
- Constant-zero stream -> never locks (S == 0 blocks match count); err_count 0.
- Clean stream with bit_valid toggled randomly (50%) -> lock after 49 valid bits; no spurious errors; state frozen on gaps.
- clear_cnt asserted same cycle as an injected error with err_count = 5 -> err_pulse high, err_count = 0; rst_n low while locked -> next cycle locked 0, err_count 0.
